// File: rtl/wb_master_seq.sv
// Wishbone classic-cycle initiator: turns local single/burst commands into one
// WB cycle per beat and returns one registered response per beat.
module wb_master_seq #(
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned DAT_W   = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             rsp_last,
  output logic             busy,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic [DAT_W-1:0] wbm_dat_i,
  input  logic             wbm_ack_i
);

  localparam int unsigned      TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADR_W-1:0] ADR_STEP = ADR_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               cyc_q, cyc_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_last_q, rsp_last_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    len_d       = len_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          len_d   = cmd_len;
          beat_d  = '0;
          tmo_d   = '0;
          cyc_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack on the expiring edge still counts as a normal completion.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_last_d  = (beat_q == len_q);
          state_d     = RESP;
        end else if (tmo_q == TMO_LAST) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            adr_d   = adr_q + ADR_STEP;
            tmo_d   = '0;
            cyc_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_last  = rsp_last_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Self-checking bench for wb_master_seq: command table with a behavioural
// Wishbone slave, beat/response scoreboards and hand-written corner cases.
module tb_wb_master_seq;

  localparam int unsigned ADR_W   = 32;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_dat;
  logic [3:0]       cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic             rsp_valid, rsp_ready, rsp_err, rsp_last, busy;
  logic [DAT_W-1:0] rsp_dat;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]       wbm_sel_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [DAT_W-1:0] wbm_dat_o, wbm_dat_i;

  wb_master_seq #(.ADR_W(ADR_W), .DAT_W(DAT_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [3:0]  len;
    int          ack_lat;   // REQ clock on which the slave acks; 0 = never
    logic [31:0] rd_xor;    // slave read data = address ^ rd_xor
    int          exp_beats;
    int          exp_rsp;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } rsp_t;

  beat_t       exp_beat_q[$];
  rsp_t        exp_rsp_q[$];
  vec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  int          n_beats = 0;
  int          n_rsp = 0;
  int          cur_ack_lat = 1;
  logic [31:0] cur_rd_xor = '0;
  logic        stray_ack = 1'b0;
  int          cyc_seen = 0;
  logic        acked_prev = 1'b0;
  beat_t       eb;
  rsp_t        er;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Slave model plus WB-side and response-side monitors, all on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc_seen   = 0;
      acked_prev = 1'b0;
      wbm_ack_i  = 1'b0;
      wbm_dat_i  = '0;
      exp_beat_q.delete();
      exp_rsp_q.delete();
    end else begin
      if (acked_prev) chk("cyc_low_after_ack", 32'(wbm_cyc_o), 32'd0);
      acked_prev = 1'b0;
      if (wbm_cyc_o) begin
        cyc_seen++;
        chk("stb", 32'(wbm_stb_o), 32'd1);
        if (cyc_seen == 1) begin
          n_beats++;
          if (exp_beat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got cycle at 0x%0h want none", wbm_adr_o);
          end else begin
            eb = exp_beat_q.pop_front();
            chk("wb_adr", wbm_adr_o, eb.adr);
            chk("wb_we",  32'(wbm_we_o), 32'(eb.we));
            chk("wb_dat", wbm_dat_o, eb.dat);
            chk("wb_sel", 32'(wbm_sel_o), 32'(eb.sel));
          end
        end else begin
          chk("wb_adr_stable", wbm_adr_o, eb.adr);
        end
        wbm_ack_i  = (cur_ack_lat != 0) && (cyc_seen == cur_ack_lat);
        wbm_dat_i  = wbm_ack_i ? (wbm_adr_o ^ cur_rd_xor) : 32'hDEAD_BEEF;
        acked_prev = wbm_ack_i;
      end else begin
        if (cyc_seen != 0)
          chk("cyc_len", 32'(cyc_seen), (cur_ack_lat != 0) ? 32'(cur_ack_lat) : 32'(TIMEOUT));
        cyc_seen  = 0;
        wbm_ack_i = stray_ack;
        wbm_dat_i = 32'hCAFE_0000;
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_rsp: got dat 0x%0h want none", rsp_dat);
        end else begin
          er = exp_rsp_q.pop_front();
          chk("rsp_dat",  rsp_dat, er.dat);
          chk("rsp_err",  32'(rsp_err), 32'(er.err));
          chk("rsp_last", 32'(rsp_last), 32'(er.last));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [3:0] len);
    int g = 0;
    while (!cmd_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int g = 0;
    while (busy && g < bound) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_beat(input logic [31:0] adr, input logic [31:0] dat,
                           input logic we, input logic [3:0] sel);
    beat_t b;
    b.adr = adr; b.dat = dat; b.we = we; b.sel = sel;
    exp_beat_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [31:0] dat, input logic err, input logic last);
    rsp_t r;
    r.dat = dat; r.err = err; r.last = last;
    exp_rsp_q.push_back(r);
  endtask

  task automatic run_vec(input vec_t v);
    int          nb;
    logic [31:0] a;
    cur_ack_lat = v.ack_lat;
    cur_rd_xor  = v.rd_xor;
    n_beats = 0;
    n_rsp   = 0;
    nb = (v.ack_lat == 0) ? 1 : int'(v.len) + 1;
    for (int b = 0; b < nb; b++) begin
      a = v.adr + 32'(4 * b);
      push_beat(a, v.dat, v.we, v.sel);
      if (v.ack_lat == 0) push_rsp(32'd0, 1'b1, 1'b1);
      else push_rsp(v.we ? 32'd0 : (a ^ v.rd_xor), 1'b0, 4'(b) == v.len);
    end
    issue(v.we, v.adr, v.dat, v.sel, v.len);
    wait_idle(1000);
    chk("beat_count", 32'(n_beats), 32'(v.exp_beats));
    chk("rsp_count",  32'(n_rsp),   32'(v.exp_rsp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int          g;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; cmd_len = '0; rsp_ready = 1'b1;

    //            we    adr            dat            sel   len   ack rd_xor        beats rsp
    vecs[0] = '{1'b1, 32'h3000_0000, 32'h0005_0003, 4'hF, 4'd0, 2,  32'h0,         1, 1};
    vecs[1] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 4'd0, 1,  32'h3000_000C, 1, 1};
    vecs[2] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         4'hF, 4'd3, 1,  32'h1234_5678, 4, 4};
    vecs[3] = '{1'b1, 32'h0000_1000, 32'hA5A5_5A5A, 4'h3, 4'd2, 3,  32'h0,         3, 3};
    vecs[4] = '{1'b0, 32'h2000_0000, 32'h0,         4'hF, 4'd2, 0,  32'h0,         1, 1};
    vecs[5] = '{1'b1, 32'h2000_0010, 32'h1111_2222, 4'h1, 4'd0, 0,  32'h0,         1, 1};
    vecs[6] = '{1'b0, 32'h0000_0100, 32'h0,         4'hC, 4'd0, 15, 32'h00FF_00FF, 1, 1};
    vecs[7] = '{1'b0, 32'h0000_0200, 32'h0,         4'hF, 4'd1, 16, 32'h7777_0000, 2, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc",       32'(wbm_cyc_o), 32'd0);
    chk("rst_stb",       32'(wbm_stb_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_dat",   rsp_dat,        32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_adr",       wbm_adr_o,      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ack while no cycle is open must be ignored.
    stray_ack = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("stray_no_rsp",  32'(rsp_valid), 32'd0);
      chk("stray_no_busy", 32'(busy),      32'd0);
      chk("stray_no_cyc",  32'(wbm_cyc_o), 32'd0);
    end
    stray_ack = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: response held, no new cycle, no new command.
    cur_ack_lat = 1;
    cur_rd_xor  = 32'h0F0F_0000;
    n_beats = 0;
    n_rsp   = 0;
    push_beat(32'h0000_2000, 32'h0, 1'b0, 4'hF);
    push_rsp(32'h0F0F_2000, 1'b0, 1'b0);
    push_beat(32'h0000_2004, 32'h0, 1'b0, 4'hF);
    push_rsp(32'h0F0F_2004, 1'b0, 1'b1);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_2000, 32'h0, 4'hF, 4'd1);
    g = 0;
    while (!rsp_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    held = rsp_dat;
    chk("bp_first_dat", held, 32'h0F0F_2000);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_dat",   rsp_dat,        held);
      chk("bp_no_cyc",     32'(wbm_cyc_o), 32'd0);
      chk("bp_cmd_ready",  32'(cmd_ready), 32'd0);
    end
    chk("bp_beats_held", 32'(n_beats), 32'd1);
    rsp_ready = 1'b1;
    wait_idle(200);
    chk("bp_beats", 32'(n_beats), 32'd2);
    chk("bp_rsps",  32'(n_rsp),   32'd2);

    // Async reset in the middle of a REQ, between clock edges.
    cur_ack_lat = 0;
    push_beat(32'h0000_4000, 32'h0, 1'b0, 4'hF);
    issue(1'b0, 32'h0000_4000, 32'h0, 4'hF, 4'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_areset_cyc", 32'(wbm_cyc_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("areset_cyc",       32'(wbm_cyc_o), 32'd0);
    chk("areset_stb",       32'(wbm_stb_o), 32'd0);
    chk("areset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("areset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("areset_busy",      32'(busy),      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
